// File: rtl/hilo_md_ctrl.sv
// HI/LO sequencer: bit-serial MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO,
// and pipeline stall while a multi-cycle op is in flight.
`timescale 1ns/1ps
module hilo_md_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mf_req,
    input  logic              cancel,
    input  logic [DATA_W-1:0] rd_hi,
    input  logic [DATA_W-1:0] rd_lo,
    output logic [DATA_W-1:0] wr_hi,
    output logic [DATA_W-1:0] wr_lo,
    output logic              busy,
    output logic              stall,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e                state_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]     opnd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  neg_res_q;
    logic                  neg_rem_q;
    logic                  div0_q;
    logic                  is_div_q;
    logic                  busy_q;
    logic                  done_q;

    // Operand conditioning at the accept edge
    logic                  op_signed;
    logic                  rs_neg;
    logic                  rt_neg;
    logic [DATA_W-1:0]     rs_mag;
    logic [DATA_W-1:0]     rt_mag;
    logic                  is_mul_op;
    logic                  is_div_op;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign rs_neg    = op_signed & rs_data[DATA_W-1];
    assign rt_neg    = op_signed & rt_data[DATA_W-1];
    assign rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

    // Shift-add step: acc = {partial product, remaining multiplier bits}
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring step: acc = {remainder, dividend bits / quotient bits}
    logic [DATA_W:0]       div_shift;
    logic [DATA_W+1:0]     div_diff;
    logic                  div_ok;
    logic [2*DATA_W-1:0]   div_next;

    assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ok    = ~div_diff[DATA_W+1];
    assign div_next  = {div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0],
                        acc_q[DATA_W-2:0], div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (cancel) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid && is_mul_op) begin
                        state_q   <= StMul;
                        acc_q     <= {{DATA_W{1'b0}}, rt_mag};
                        opnd_q    <= rs_mag;
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= 1'b0;
                        div0_q    <= 1'b0;
                        is_div_q  <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                    end else if (op_valid && is_div_op) begin
                        state_q   <= StDiv;
                        acc_q     <= {{DATA_W{1'b0}}, rs_mag};
                        opnd_q    <= rt_mag;
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= rs_neg;
                        div0_q    <= (rt_data == '0);
                        is_div_q  <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StMul: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDiv: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sign fix-up of the magnitude result, applied while presenting it in DONE
    logic [2*DATA_W-1:0]   mul_prod;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign mul_prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = div0_q ? {DATA_W{1'b1}}
                    : (neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0]);
    assign rem_fix  = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1)
                                : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        wr_hi = rd_hi;
        wr_lo = rd_lo;
        if (!cancel) begin
            if (state_q == StIdle && op_valid) begin
                if (op == OP_MTHI) wr_hi = rs_data;
                if (op == OP_MTLO) wr_lo = rs_data;
            end else if (state_q == StDone) begin
                if (is_div_q) begin
                    wr_hi = rem_fix;
                    wr_lo = quo_fix;
                end else begin
                    wr_hi = mul_prod[2*DATA_W-1:DATA_W];
                    wr_lo = mul_prod[DATA_W-1:0];
                end
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (op_valid | mf_req);

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: models HI/LO registers and checks
// results, latency, stall, MT ops, cancel and reset abort.
`timescale 1ns/1ps
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        cancel;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] wr_hi;
    logic [31:0] wr_lo;
    logic        busy;
    logic        stall;
    logic        done;

    logic        hl_init;
    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    hilo_md_ctrl #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .mf_req   (mf_req),
        .cancel   (cancel),
        .rd_hi    (hi_r),
        .rd_lo    (lo_r),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    // HI/LO registers, reset independently of the sequencer
    always @(posedge clk) begin
        if (hl_init) begin
            hi_r <= 32'hAAAA_0001;
            lo_r <= 32'h5555_0002;
        end else begin
            hi_r <= wr_hi;
            lo_r <= wr_lo;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd1: begin
                q = sa * sb;
                return q;
            end
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (!cancel) begin
                if (exp_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
                else check_eq("sb_result", {wr_hi, wr_lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check_eq(tag, 64'd0, 64'd1);
        #1;
    endtask

    task automatic mdrun(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int          b0;
        int          d0;
        e = model(o, a, b);
        exp_q.push_back(e);
        b0 = busy_cnt;
        d0 = done_cnt;
        issue(o, a, b);
        wait_idle("md_timeout");
        check_eq("busy_len", 64'(busy_cnt - b0), 64'd33);
        check_eq("done_pulse", 64'(done_cnt - d0), 64'd1);
        check_eq("hilo_reg", {hi_r, lo_r}, e);
    endtask

    initial begin
        logic [31:0] h0;
        logic [31:0] l0;
        int          d0;
        int          n;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n    = 1'b0;
        hl_init  = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        mf_req   = 1'b0;
        cancel   = 1'b0;
        repeat (2) @(negedge clk);
        hl_init = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hold", {wr_hi, wr_lo}, {32'hAAAA_0001, 32'h5555_0002});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_hold", {hi_r, lo_r}, {32'hAAAA_0001, 32'h5555_0002});

        mdrun(3'd1, 32'hFFFF_FFFD, 32'd5);
        mdrun(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mdrun(3'd3, 32'hFFFF_FFF9, 32'd2);
        mdrun(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        mdrun(3'd4, 32'd7, 32'd0);
        mdrun(3'd3, 32'hFFFF_FFF9, 32'd0);
        mdrun(3'd3, 32'd7, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            mdrun(ro, ra, rb);
        end

        // MTHI in IDLE
        @(negedge clk);
        l0 = lo_r;
        op_valid = 1'b1;
        op       = 3'd5;
        rs_data  = 32'h0000_1234;
        #1;
        check_eq("mthi_wr", 64'(wr_hi), 64'h1234);
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
        #1;
        check_eq("mthi_reg", {hi_r, lo_r}, {32'h0000_1234, l0});
        check_eq("mthi_busy", 64'(busy), 64'd0);

        // MTLO + MFHI presented mid-MULTU: stalled until E33
        exp_q.push_back(model(3'd2, 32'h0001_0000, 32'h0003_0000));
        issue(3'd2, 32'h0001_0000, 32'h0003_0000);
        repeat (4) @(negedge clk);
        op_valid = 1'b1;
        op       = 3'd6;
        rs_data  = 32'h55;
        mf_req   = 1'b1;
        #1;
        n = 0;
        while (busy && n < 40) begin
            check_eq("stall_mid", 64'(stall), 64'd1);
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) check_eq("stall_timeout", 64'd0, 64'd1);
        check_eq("stall_clear", 64'(stall), 64'd0);
        check_eq("prod_after_e33", {hi_r, lo_r}, {32'd3, 32'd0});
        check_eq("mtlo_wr", 64'(wr_lo), 64'h55);
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
        mf_req   = 1'b0;
        #1;
        check_eq("mtlo_applied", {hi_r, lo_r}, {32'd3, 32'h55});

        // cancel at iteration 10
        h0 = hi_r;
        l0 = lo_r;
        d0 = done_cnt;
        issue(3'd2, 32'h1234_5678, 32'h9);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check_eq("cancel_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("cancel_nodone", 64'(done_cnt - d0), 64'd0);
        check_eq("cancel_hilo", {hi_r, lo_r}, {h0, l0});

        // reset at iteration 20
        d0 = done_cnt;
        issue(3'd1, 32'hFFFF_0000, 32'h7777);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rst_mid_nodone", 64'(done_cnt - d0), 64'd0);
        check_eq("rst_mid_hilo", {hi_r, lo_r}, {h0, l0});

        // cancel suppresses MTHI in IDLE; invalid op ignored
        op_valid = 1'b1;
        op       = 3'd5;
        rs_data  = 32'hDEAD_BEEF;
        cancel   = 1'b1;
        #1;
        check_eq("mt_cancel_wr", 64'(wr_hi), 64'(h0));
        @(negedge clk);
        cancel = 1'b0;
        op     = 3'd7;
        #1;
        check_eq("bad_op_wr", {wr_hi, wr_lo}, {h0, l0});
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
        #1;
        check_eq("bad_op_busy", 64'(busy), 64'd0);
        check_eq("mt_cancel_hilo", {hi_r, lo_r}, {h0, l0});
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
